// File: rtl/board_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_io_pkg
//  Description : Shared constants and types for the board input conditioner
//                (clock rate, default filter/hold lengths, debounce states).
//  Revision    : 1.0 - initial release
// ============================================================================
package board_io_pkg;

   localparam int CLK_FREQ_HZ      = 50_000_000;
   localparam int DEBOUNCE_MS      = 5;
   localparam int LONG_PRESS_MS    = 1000;
   localparam int CYCLES_PER_MS    = CLK_FREQ_HZ / 1000;

   // 5 ms of stable level accepts a new value; 1 s held counts as a long press
   localparam int DEFAULT_DEBOUNCE_CYCLES   = CYCLES_PER_MS * DEBOUNCE_MS;
   localparam int DEFAULT_LONG_PRESS_CYCLES = CYCLES_PER_MS * LONG_PRESS_MS;

   typedef enum logic [0:0] {
      DB_STABLE = 1'b0,
      DB_COUNT  = 1'b1
   } debounce_state_e;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One input channel: multi-stage synchroniser, polarity
//                normalisation, two-state debounce FSM with saturating
//                counter, and registered rise/fall pulses aligned with the
//                first cycle the new accepted level is visible.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
   import board_io_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit RESET_LEVEL     = 1'b0,
   parameter bit INVERT          = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  C_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   debounce_state_e        r_state;
   debounce_state_e        w_state_nxt;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_nxt;
   logic                   w_flip;
   logic                   r_q;
   logic                   r_rise;
   logic                   r_fall;

   // Synchroniser chain; resets to the pin's inactive level so no event follows reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      end
   end

   // Everything downstream of the synchroniser is active-high
   assign w_s = r_sync[SYNC_STAGES-1] ^ INVERT;

   // Next-state logic: r_cnt holds how many consecutive mismatches were already seen
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_flip      = 1'b0;
      case (r_state)
         DB_STABLE: begin
            if (w_s != r_q) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  w_flip = 1'b1;
               end else begin
                  w_state_nxt = DB_COUNT;
                  w_cnt_nxt   = CW'(1);
               end
            end
         end
         DB_COUNT: begin
            if (w_s == r_q) begin
               w_state_nxt = DB_STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == C_LAST) begin
               w_flip      = 1'b1;
               w_state_nxt = DB_STABLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = DB_STABLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State, accepted level and edge pulses all update on the same edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= DB_STABLE;
         r_cnt   <= '0;
         r_q     <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_flip) begin
            r_q <= w_s;
         end
         r_rise  <= w_flip & w_s;
         r_fall  <= w_flip & ~w_s;
      end
   end

   assign o_level = r_q;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/board_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : board_input_conditioner
//  Description : Front-end for board switches and push-buttons. Each channel
//                is synchronised, debounced and edge-annotated; buttons are
//                normalised to active-high and get a long-press detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_input_conditioner
   import board_io_pkg::*;
#(
   parameter int NUM_SW            = 17,
   parameter int NUM_BTN           = 4,
   parameter int SYNC_STAGES       = 2,
   parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
   parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_SW-1:0]  i_sw,
   input  logic [NUM_BTN-1:0] i_btn,
   output logic [NUM_SW-1:0]  o_sw,
   output logic [NUM_SW-1:0]  o_sw_change,
   output logic [NUM_BTN-1:0] o_btn,
   output logic [NUM_BTN-1:0] o_btn_press,
   output logic [NUM_BTN-1:0] o_btn_release,
   output logic [NUM_BTN-1:0] o_btn_long
);

   localparam int             HW         = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [HW-1:0]  C_HOLD_MAX = HW'(LONG_PRESS_CYCLES);
   localparam logic [HW-1:0]  C_HOLD_PRE = HW'(LONG_PRESS_CYCLES - 1);

   logic [NUM_SW-1:0] w_sw_rise;
   logic [NUM_SW-1:0] w_sw_fall;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (1'b0),
         .INVERT          (1'b0)
      ) u_ch (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_raw   (i_sw[i]),
         .o_level (o_sw[i]),
         .o_rise  (w_sw_rise[i]),
         .o_fall  (w_sw_fall[i])
      );
   end

   assign o_sw_change = w_sw_rise | w_sw_fall;

   for (genvar j = 0; j < NUM_BTN; j++) begin : g_btn
      logic          r_long;
      logic [HW-1:0] r_hold;

      debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (BTN_ACTIVE_LOW),
         .INVERT          (BTN_ACTIVE_LOW)
      ) u_ch (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_raw   (i_btn[j]),
         .o_level (o_btn[j]),
         .o_rise  (o_btn_press[j]),
         .o_fall  (o_btn_release[j])
      );

      // Saturating hold counter; the pulse fires once, on the edge it reaches the threshold
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_hold <= '0;
            r_long <= 1'b0;
         end else if (!o_btn[j]) begin
            r_hold <= '0;
            r_long <= 1'b0;
         end else if (r_hold != C_HOLD_MAX) begin
            r_hold <= r_hold + HW'(1);
            r_long <= (r_hold == C_HOLD_PRE);
         end else begin
            r_long <= 1'b0;
         end
      end

      // A release landing on the threshold edge drops the level in the same
      // cycle the pulse would appear, so gating by the level lets release win.
      assign o_btn_long[j] = r_long & o_btn[j];
   end

endmodule
`default_nettype wire
